// File: rtl/btb_predictor_if.sv
// Fetch-side lookup and EX-side training bundle for btb_predictor.
// RAS_DEPTH sizes the occupancy count and must match the predictor instance.
interface btb_predictor_if #(
   parameter int unsigned RAS_DEPTH = 8
);
   localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

   logic [31:0]      pc_i;
   logic             pred_hit_o;
   logic             pred_taken_o;
   logic [31:0]      pred_pc_o;
   logic             upd_valid_i;
   logic [31:0]      upd_pc_i;
   logic             upd_taken_i;
   logic [31:0]      upd_target_i;
   logic             upd_is_call_i;
   logic             upd_is_ret_i;
   logic             inv_i;
   logic [CNT_W-1:0] ras_count_o;

   modport master (
      output pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
      output upd_is_call_i, upd_is_ret_i, inv_i,
      input  pred_hit_o, pred_taken_o, pred_pc_o, ras_count_o
   );

   modport slave (
      input  pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
      input  upd_is_call_i, upd_is_ret_i, inv_i,
      output pred_hit_o, pred_taken_o, pred_pc_o, ras_count_o
   );
endinterface

// File: rtl/btb_predictor.sv
// Set-associative BTB with saturating direction counters and per-set round-robin replacement.
// Define BTB_RAS_EN to compile in the return address stack used for return prediction.
module btb_predictor #(
   parameter int unsigned ENTRIES   = 64,
   parameter int unsigned WAYS      = 2,
   parameter int unsigned CTR_BITS  = 2,
   parameter int unsigned RAS_DEPTH = 8
) (
   input logic           clk,
   input logic           rst,
   btb_predictor_if.slave bus
);
   localparam int unsigned SETS  = ENTRIES / WAYS;
   localparam int unsigned IDX   = $clog2(SETS);
   localparam int unsigned IDX_W = (IDX > 0) ? IDX : 1;
   localparam int unsigned TAG_W = 30 - IDX;
   localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int unsigned RAS_W = $clog2(RAS_DEPTH);
   localparam logic [CTR_BITS-1:0] WT   = CTR_BITS'(2 ** (CTR_BITS - 1));
   localparam logic [CTR_BITS-1:0] CMAX = {CTR_BITS{1'b1}};

   function automatic logic [IDX_W-1:0] get_idx(input logic [31:0] pc);
      logic [31:0] s;
      s = (pc >> 2) & (SETS - 1);
      return s[IDX_W-1:0];
   endfunction

   function automatic logic [TAG_W-1:0] get_tag(input logic [31:0] pc);
      logic [31:0] s;
      s = pc >> (IDX + 2);
      return s[TAG_W-1:0];
   endfunction

   logic                valid_q  [SETS][WAYS];
   logic [TAG_W-1:0]    tag_q    [SETS][WAYS];
   logic [31:0]         target_q [SETS][WAYS];
   logic [CTR_BITS-1:0] ctr_q    [SETS][WAYS];
   logic                is_ret_q [SETS][WAYS];
   logic [WAY_W-1:0]    ptr_q    [SETS];

   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic             lk_hit;
   logic [WAY_W-1:0] lk_way;

   logic [IDX_W-1:0] up_idx;
   logic [TAG_W-1:0] up_tag;
   logic             up_hit;
   logic [WAY_W-1:0] up_way;
   logic             up_free;
   logic [WAY_W-1:0] up_victim;

`ifdef BTB_RAS_EN
   logic [31:0]    ras_q [RAS_DEPTH];
   logic [RAS_W-1:0] ras_top_q;
   logic [RAS_W:0]   ras_cnt_q;
   logic [31:0]      push_pc;
`endif

   // Lowest matching way wins when several ways alias the same tag.
   always_comb begin
      lk_idx = get_idx(bus.pc_i);
      lk_tag = get_tag(bus.pc_i);
      lk_hit = 1'b0;
      lk_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!lk_hit && valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
            lk_hit = 1'b1;
            lk_way = WAY_W'(w);
         end
      end
   end

   always_comb begin
      bus.pred_hit_o   = lk_hit;
      bus.pred_taken_o = lk_hit && ctr_q[lk_idx][lk_way][CTR_BITS-1];
      bus.pred_pc_o    = bus.pred_taken_o ? target_q[lk_idx][lk_way] : bus.pc_i + 32'd4;
`ifdef BTB_RAS_EN
      if (lk_hit && is_ret_q[lk_idx][lk_way] && ras_cnt_q != '0) begin
         bus.pred_taken_o = 1'b1;
         bus.pred_pc_o    = ras_q[ras_top_q];
      end
`endif
   end

   always_comb begin
      up_idx    = get_idx(bus.upd_pc_i);
      up_tag    = get_tag(bus.upd_pc_i);
      up_hit    = 1'b0;
      up_way    = '0;
      up_free   = 1'b0;
      up_victim = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!up_hit && valid_q[up_idx][w] && tag_q[up_idx][w] == up_tag) begin
            up_hit = 1'b1;
            up_way = WAY_W'(w);
         end
         if (!up_free && !valid_q[up_idx][w]) begin
            up_free   = 1'b1;
            up_victim = WAY_W'(w);
         end
      end
      if (!up_free) up_victim = ptr_q[up_idx];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            ptr_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               valid_q[s][w]  <= 1'b0;
               tag_q[s][w]    <= '0;
               target_q[s][w] <= '0;
               ctr_q[s][w]    <= '0;
               is_ret_q[s][w] <= 1'b0;
            end
         end
      end else if (bus.inv_i) begin
         for (int s = 0; s < SETS; s++) begin
            ptr_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
         end
      end else if (bus.upd_valid_i) begin
         if (up_hit) begin
            if (bus.upd_taken_i) begin
               if (target_q[up_idx][up_way] != bus.upd_target_i) begin
                  target_q[up_idx][up_way] <= bus.upd_target_i;
                  ctr_q[up_idx][up_way]    <= WT;
               end else if (ctr_q[up_idx][up_way] != CMAX) begin
                  ctr_q[up_idx][up_way] <= ctr_q[up_idx][up_way] + 1'b1;
               end
            end else if (ctr_q[up_idx][up_way] != '0) begin
               ctr_q[up_idx][up_way] <= ctr_q[up_idx][up_way] - 1'b1;
            end
            is_ret_q[up_idx][up_way] <= bus.upd_is_ret_i;
         end else if (bus.upd_taken_i) begin
            valid_q[up_idx][up_victim]  <= 1'b1;
            tag_q[up_idx][up_victim]    <= up_tag;
            target_q[up_idx][up_victim] <= bus.upd_target_i;
            ctr_q[up_idx][up_victim]    <= WT;
            is_ret_q[up_idx][up_victim] <= bus.upd_is_ret_i;
            // Pointer only moves when a live entry is evicted.
            if (!up_free) begin
               ptr_q[up_idx] <= (ptr_q[up_idx] == WAY_W'(WAYS - 1)) ? '0 : ptr_q[up_idx] + 1'b1;
            end
         end
      end
   end

`ifdef BTB_RAS_EN
   assign push_pc = bus.upd_pc_i + 32'd4;

   // Circular stack: a push when full overwrites the oldest slot, which is the next one up.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ras_top_q <= '0;
         ras_cnt_q <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      end else if (bus.inv_i) begin
         ras_top_q <= '0;
         ras_cnt_q <= '0;
      end else if (bus.upd_valid_i) begin
         if (bus.upd_is_call_i && bus.upd_is_ret_i && ras_cnt_q != '0) begin
            ras_q[ras_top_q] <= push_pc;
         end else if (bus.upd_is_call_i) begin
            ras_q[ras_top_q + 1'b1] <= push_pc;
            ras_top_q               <= ras_top_q + 1'b1;
            if (ras_cnt_q != (RAS_W + 1)'(RAS_DEPTH)) ras_cnt_q <= ras_cnt_q + 1'b1;
         end else if (bus.upd_is_ret_i && ras_cnt_q != '0) begin
            ras_top_q <= ras_top_q - 1'b1;
            ras_cnt_q <= ras_cnt_q - 1'b1;
         end
      end
   end

   assign bus.ras_count_o = ras_cnt_q;
`else
   assign bus.ras_count_o = '0;
`endif

endmodule

// File: doc/btb_predictor.md
# btb_predictor

Parametrised set-associative branch target buffer with saturating direction counters, per-set round-robin replacement and an optional return address stack. It supersedes the fixed direct-mapped BTB inside the fetch stage. It sits beside the fetch stage: lookup is combinational on the current fetch PC, and training arrives from the EX stage one update per cycle.

## Interface
- `ENTRIES`, 64: total BTB entries; power of two.
- `WAYS`, 2: associativity; power of two, ≤ ENTRIES. SETS = ENTRIES/WAYS, IDX = log2(SETS), tag = pc[31:IDX+2], index = pc[IDX+1:2].
- `CTR_BITS`, 2: direction counter width, 1..4. Weak-taken value WT = 2^(CTR_BITS-1).
- `RAS_DEPTH`, 8: return stack entries; power of two ≥ 2. Used only with RAS_EN.

Ports:
- `clk` in 1: the block's single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `pc_i` in 32: fetch PC to look up.
- `pred_hit_o` out 1: tag hit in the indexed set.
- `pred_taken_o` out 1: predict redirect.
- `pred_pc_o` out 32: predicted next PC.
- `upd_valid_i` in 1: training strobe from EX.
- `upd_pc_i` in 32: PC of the resolved control-flow instruction.
- `upd_taken_i` in 1: resolved taken.
- `upd_target_i` in 32: resolved target; meaningful when taken.
- `upd_is_call_i` in 1: instruction is a call (JAL/JALR with rd=x1/x5); qualified by upd_valid_i.
- `upd_is_ret_i` in 1: instruction is a return (JALR rs1=x1/x5, rd=x0); qualified by upd_valid_i.
- `inv_i` in 1: invalidate all entries (FENCE.I, SFENCE.VMA).
- `ras_count_o` out log2(RAS_DEPTH)+1: RAS occupancy; 0 without RAS_EN.

## Operation
- Entry fields: valid, tag, target[31:0], ctr[CTR_BITS-1:0], is_ret. Each set also holds a log2(WAYS)-bit replacement pointer.
- Lookup, combinational:
  - hit = any way in set[index] has valid and a matching tag.
  - If more than one way matches, the lowest way wins.
  - taken = hit && ctr[MSB].
  - pred_pc_o = taken ? target : pc_i + 4, with wrap modulo 2^32.
- Update, on a clock edge with upd_valid_i=1 and inv_i=0, tag match in set[index(upd_pc_i)]:
  - Taken and target differs from the stored target: target ← upd_target_i, ctr ← WT.
  - Taken and target matches: ctr saturating +1.
  - Not taken: ctr saturating −1; target is kept.
  - is_ret ← upd_is_ret_i in every case.
- Update on a tag miss:
  - Taken: allocate. Victim is the lowest invalid way; if none is invalid, the way at the set's pointer, and the pointer increments modulo WAYS. The new entry gets valid=1, tag, target, ctr=WT, is_ret.
  - Not taken: no allocation and no state change.
- The pointer advances only on allocations that evict a valid entry.
- inv_i clears every valid bit and every pointer and empties the RAS. It has priority over a simultaneous update, which is dropped.

## Timing
- Lookup has zero-cycle latency; outputs follow pc_i combinationally.
- Updates and invalidates are visible to lookup on the cycle after the edge.
- A same-cycle lookup of the entry being updated sees the old contents.
- Reset clears all valid bits, ctr, target, is_ret, pointers and RAS pointer/count to 0. Right after reset: pred_hit_o=0, pred_taken_o=0, pred_pc_o=pc_i+4, ras_count_o=0.
- Reset asserted mid-operation clears state immediately, asynchronously. A pending update is lost.
- One update per cycle. There is no backpressure; upd_valid_i is never stalled.

## Configuration
- `BTB_RAS_EN` defined: RAS is compiled in. It is a circular stack with top pointer and count, trained non-speculatively at update time.
  - upd_is_call_i: push upd_pc_i+4.
  - upd_is_ret_i: pop.
  - Both set: pop then push, i.e. the top is replaced and count is unchanged.
  - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Pop when empty: no change.
  - Lookup hit on an entry with is_ret=1 and count>0: pred_taken_o=1 and pred_pc_o=RAS top, regardless of ctr.
- `BTB_RAS_EN` undefined: no RAS storage. is_ret is still stored but ignored, ras_count_o=0, and returns predict from target/ctr like any other branch.

## Test plan
- Reset, pc_i=0x8000_0000 → hit=0, taken=0, pred_pc=0x8000_0004.
- Taken update pc=0x100, target=0x200, then lookup 0x100 → hit=1, taken=1 (ctr=2), pred_pc=0x200. A second taken update gives ctr=3. Two not-taken updates give ctr=1, taken=0, pred_pc=0x104.
- WAYS=2, SETS=32: taken updates at 0x100, 0x180, 0x200, all index 0 → 0x100 is evicted (pointer 0→1) and 0x180/0x200 still hit. Not-taken update at 0x300 allocates nothing.
- Same-cycle update of 0x100 and lookup of 0x100 → the lookup reports the old value; the new value appears next cycle. inv_i together with upd_valid_i → all lookups miss next cycle.
- BTB_RAS_EN, RAS_DEPTH=8: 9 calls from pc 0x1000+4k → ras_count=8, top=0x1024. Return entry trained at 0x2000 and hit with count>0 → pred_pc=0x1024. Pops at empty keep count=0.
- rst pulsed asynchronously between edges while entries are valid → outputs drop to the reset values at once; the next lookup misses.
